// File: rtl/lifo_stack_param_pkg.sv
// Shared constants for the LIFO stack: op encoding, default sizing and count-width helper.
// Optional almost-full/almost-empty flags are enabled by defining LIFO_ALMOST_FLAGS_EN.
package lifo_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 16;

    // Encoding is {push, pop} so the decode is a plain concatenation.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_param_if.sv
// Request/response bundle between a stack user (master) and the stack (slave).
// almost_full/almost_empty exist only when LIFO_ALMOST_FLAGS_EN is defined.
interface lifo_stack_param_if
    import lifo_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic                            en;
    logic                            push;
    logic                            pop;
    logic [DW-1:0]                   din;
    logic                            clr_err;
    logic [DW-1:0]                   dout;
    logic                            dout_valid;
    logic [count_width(DEPTH)-1:0]   count;
    logic                            empty;
    logic                            full;
    logic                            overflow;
    logic                            underflow;
`ifdef LIFO_ALMOST_FLAGS_EN
    logic                            almost_full;
    logic                            almost_empty;
`endif

    modport master (
        output en, push, pop, din, clr_err,
        input  dout, dout_valid, count, empty, full, overflow, underflow
`ifdef LIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  en, push, pop, din, clr_err,
        output dout, dout_valid, count, empty, full, overflow, underflow
`ifdef LIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/lifo_stack_param_regfile.sv
// DEPTH x DW storage for the stack: one synchronous write port, one asynchronous read port.
// Storage is intentionally never reset.
module lifo_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with top-replace, registered pop data and sticky error flags.
// Define LIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty outputs.
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = 2,
    parameter int AE_THRESH = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    lifo_stack_param_if.slave  bus
);
    localparam int CW = count_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    if (DW < 1 || DEPTH < 2 || AF_THRESH < 0 || AE_THRESH < 0) begin : g_param_check
        $error("lifo_stack_param: illegal parameter combination");
    end

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic [1:0]    w_op;
    logic          w_empty;
    logic          w_full;
    logic          w_we;
    logic          w_rd;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_top;
    logic [DW-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_top   = AW'(r_count - CW'(1));

    always_comb begin
        w_op         = bus.en ? {bus.push, bus.pop} : OP_NONE;
        w_we         = 1'b0;
        w_rd         = 1'b0;
        w_ovf_set    = 1'b0;
        w_udf_set    = 1'b0;
        w_waddr      = AW'(r_count);
        w_count_next = r_count;
        case (w_op)
            OP_PUSH: begin
                if (!w_full) begin
                    w_we         = 1'b1;
                    w_count_next = r_count + CW'(1);
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_rd         = 1'b1;
                    w_count_next = r_count - CW'(1);
                end else begin
                    w_udf_set = 1'b1;
                end
            end
            OP_REPL: begin
                // Replace the top in place; on an empty stack only the push half can execute.
                if (!w_empty) begin
                    w_we    = 1'b1;
                    w_rd    = 1'b1;
                    w_waddr = w_top;
                end else begin
                    w_we         = 1'b1;
                    w_count_next = r_count + CW'(1);
                    w_udf_set    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    lifo_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .Clk     (Clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.din),
        .i_raddr (w_top),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_dout_valid <= w_rd;
            if (w_rd) begin
                r_dout <= w_rdata;
            end
            // A fresh error outranks a clear arriving in the same cycle.
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~bus.clr_err);
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

`ifdef LIFO_ALMOST_FLAGS_EN
    assign bus.almost_full  = ((DEPTH - int'(r_count)) <= AF_THRESH);
    assign bus.almost_empty = (int'(r_count) <= AE_THRESH);
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed testbench for lifo_stack_param (DW=8, DEPTH=16); almost-flag test runs when
// LIFO_ALMOST_FLAGS_EN is defined.
module tb_lifo_stack_param;
    import lifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = count_width(DEPTH);

    logic Clk;
    logic Rst;
    int   n_checks;
    int   n_fail;

    lifo_stack_param_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    lifo_stack_param #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (2),
        .AE_THRESH (2)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic push, input logic pop,
                        input logic [DW-1:0] din, input logic clr);
        bus.en      = en;
        bus.push    = push;
        bus.pop     = pop;
        bus.din     = din;
        bus.clr_err = clr;
        @(posedge Clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        $display("t=%0t en=%0b push=%0b pop=%0b din=%02h -> count=%0d dout=%02h valid=%0b ovf=%0b udf=%0b",
                 $time, en, push, pop, din, bus.count, bus.dout, bus.dout_valid,
                 bus.overflow, bus.underflow);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.full); end
        n_checks++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %02h want 00", bus.dout); end
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.dout_valid); end
        n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %02b want 00", {bus.overflow, bus.underflow}); end
`ifdef LIFO_ALMOST_FLAGS_EN
        n_checks++; if ({bus.almost_full, bus.almost_empty} !== 2'b01) begin n_fail++; $display("FAIL reset_almost got %02b want 01", {bus.almost_full, bus.almost_empty}); end
`endif
    endtask

    task automatic test_push_pop();
        logic [DW-1:0] exp_vals [3];
        exp_vals = '{8'h33, 8'h22, 8'h11};
        step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL pp_count got %0d want 3", bus.count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++; if (bus.dout !== exp_vals[i] || bus.dout_valid !== 1'b1) begin
                n_fail++; $display("FAIL pp_pop%0d got %02h/%0b want %02h/1", i, bus.dout, bus.dout_valid, exp_vals[i]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h11) begin n_fail++; $display("FAIL pp_hold got %02h/%0b want 11/0", bus.dout, bus.dout_valid); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty got %0b want 1", bus.empty); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        end
        n_checks++; if (bus.full !== 1'b1 || bus.count !== CW'(16)) begin n_fail++; $display("FAIL full_flag got %0b/%0d want 1/16", bus.full, bus.count); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got %0b want 0", bus.overflow); end
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1 || bus.count !== CW'(16)) begin n_fail++; $display("FAIL ovf_set got %0b/%0d want 1/16", bus.overflow, bus.count); end
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (bus.dout !== 8'h4F || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop got %02h/%0b want 4F/1", bus.dout, bus.dout_valid); end
        n_checks++; if (bus.full !== 1'b0 || bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got full=%0b ovf=%0b want 0/1", bus.full, bus.overflow); end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %0b want 0", bus.overflow); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        n_checks++; if (bus.dout !== 8'h40 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain got %02h/%0b want 40/1", bus.dout, bus.empty); end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (bus.underflow !== 1'b1 || bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL udf_set got %0b/%0b want 1/0", bus.underflow, bus.dout_valid); end
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL udf_count got %0d want 0", bus.count); end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %0b want 0", bus.underflow); end
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_prio got %0b want 1", bus.underflow); end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_replace();
        step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
        n_checks++; if (bus.dout !== 8'h33 || bus.dout_valid !== 1'b1 || bus.count !== CW'(3)) begin
            n_fail++; $display("FAIL repl got %02h/%0b/%0d want 33/1/3", bus.dout, bus.dout_valid, bus.count);
        end
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (bus.dout !== 8'hAA || bus.count !== CW'(2)) begin n_fail++; $display("FAIL repl_next got %02h/%0d want AA/2", bus.dout, bus.count); end
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++; if (bus.dout !== 8'h11 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL repl_drain got %02h/%0b want 11/1", bus.dout, bus.empty); end
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
        n_checks++; if (bus.count !== CW'(1) || bus.underflow !== 1'b1 || bus.dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL repl_empty got %0d/%0b/%0b want 1/1/0", bus.count, bus.underflow, bus.dout_valid);
        end
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        n_checks++; if (bus.dout !== 8'h5A || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL repl_empty_pop got %02h/%0b want 5A/0", bus.dout, bus.underflow); end
    endtask

    task automatic test_enable_reset();
        step(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h66, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'(i % 2), 1'((i + 1) % 2), 8'hC0 + 8'(i), 1'b0);
        end
        n_checks++; if (bus.count !== CW'(1) || bus.dout !== 8'h66 || bus.dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL en_hold got %0d/%02h/%0b want 1/66/0", bus.count, bus.dout, bus.dout_valid);
        end
        n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL en_flags got %02b want 00", {bus.overflow, bus.underflow}); end
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        Rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        Rst = 1'b0;
        n_checks++; if (bus.count !== CW'(0) || bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid got %0d/%0b/%02h want 0/0/00", bus.count, bus.dout_valid, bus.dout);
        end
    endtask

`ifdef LIFO_ALMOST_FLAGS_EN
    task automatic test_almost();
        do_reset();
        for (int c = 0; c <= DEPTH; c++) begin
            n_checks++; if (bus.almost_empty !== (c <= 2) || bus.almost_full !== (c >= 14)) begin
                n_fail++; $display("FAIL almost_c%0d got ae=%0b af=%0b want ae=%0b af=%0b",
                                   c, bus.almost_empty, bus.almost_full, (c <= 2), (c >= 14));
            end
            if (c < DEPTH) step(1'b1, 1'b1, 1'b0, 8'(c), 1'b0);
        end
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        Rst         = 1'b1;
        bus.en      = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.clr_err = 1'b0;
        test_reset();
        test_push_pop();
        test_full_overflow();
        test_underflow();
        test_replace();
        test_enable_reset();
`ifdef LIFO_ALMOST_FLAGS_EN
        test_almost();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
